// File: rtl/sigmoid_neuron_trainer_pkg.sv
// Shared Q8.8 types, sigmoid PWL constants, phase enum and fixed-point helpers.
// Build option NEURON_SAT_EN: saturate products, sums and updates instead of wrapping.
package nn_pkg;

  localparam int FRAC = 8;

  typedef logic signed [15:0] q8_8_t;

  // PWL sigmoid: breakpoints on |z|, slopes as right-shift counts, offsets in Q8.8
  localparam logic [16:0] SIG_U_SAT   = 17'd1280;
  localparam logic [16:0] SIG_U_HI    = 17'd608;
  localparam logic [16:0] SIG_U_LO    = 17'd256;
  localparam int          SIG_SH_HI   = 5;
  localparam int          SIG_SH_MID  = 3;
  localparam int          SIG_SH_LO   = 2;
  localparam logic [16:0] SIG_OFF_HI  = 17'd216;
  localparam logic [16:0] SIG_OFF_MID = 17'd160;
  localparam logic [16:0] SIG_OFF_LO  = 17'd128;
  localparam logic [16:0] SIG_ONE     = 17'd256;

  typedef enum logic [2:0] {
    S_IDLE, S_FPH, S_FPO, S_BPO, S_BPH, S_DONE
  } phase_t;

  function automatic logic signed [31:0] mul(q8_8_t a, q8_8_t c);
    logic signed [31:0] p;
    p = 32'(a) * 32'(c);
    return p >>> FRAC;
  endfunction

  function automatic q8_8_t sat16(logic signed [31:0] v);
    if (v > 32'sd32767)  return q8_8_t'(16'h7FFF);
    if (v < -32'sd32768) return q8_8_t'(16'h8000);
    return q8_8_t'(v);
  endfunction

  function automatic q8_8_t fit(logic signed [31:0] v);
`ifdef NEURON_SAT_EN
    return sat16(v);
`else
    return q8_8_t'(v);
`endif
  endfunction

  // Odd-symmetric around 0.5: negative z mirrors the positive curve
  function automatic q8_8_t sig(q8_8_t z);
    logic signed [16:0] zs;
    logic [16:0] u;
    logic [16:0] f;
    zs = 17'(z);
    u  = unsigned'(zs[16] ? -zs : zs);
    if (u >= SIG_U_SAT)     f = SIG_ONE;
    else if (u >= SIG_U_HI) f = (u >> SIG_SH_HI) + SIG_OFF_HI;
    else if (u >= SIG_U_LO) f = (u >> SIG_SH_MID) + SIG_OFF_MID;
    else                    f = (u >> SIG_SH_LO) + SIG_OFF_LO;
    return z[15] ? q8_8_t'(SIG_ONE - f) : q8_8_t'(f);
  endfunction

endpackage

// File: rtl/sigmoid_neuron_trainer_arch_ctrl.sv
// Phase sequencer: FPH/FPO/BPO/BPH schedule with epoch counter; strobes are registered one-hot.
module arch_ctrl
  import nn_pkg::*;
#(
  parameter int EPOCHS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tr,
  input  logic vl,
  output logic fph,
  output logic fpo,
  output logic bpo,
  output logic bph,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(EPOCHS + 1);

  phase_t        st;
  logic [CW-1:0] cnt;
  logic          trn;

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= S_IDLE;
      cnt  <= '0;
      trn  <= 1'b0;
      fph  <= 1'b0;
      fpo  <= 1'b0;
      bpo  <= 1'b0;
      bph  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      fph  <= 1'b0;
      fpo  <= 1'b0;
      bpo  <= 1'b0;
      bph  <= 1'b0;
      done <= 1'b0;
      case (st)
        S_IDLE: begin
          if (tr || vl) begin
            trn  <= tr;
            cnt  <= '0;
            st   <= S_FPH;
            fph  <= 1'b1;
            busy <= 1'b1;
          end
        end
        S_FPH: begin
          st  <= S_FPO;
          fpo <= 1'b1;
        end
        S_FPO: begin
          if (trn) begin
            st  <= S_BPO;
            bpo <= 1'b1;
          end else begin
            st   <= S_DONE;
            done <= 1'b1;
          end
        end
        S_BPO: begin
          st  <= S_BPH;
          bph <= 1'b1;
        end
        S_BPH: begin
          if (cnt == CW'(EPOCHS - 1)) begin
            cnt  <= '0;
            st   <= S_DONE;
            done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            st  <= S_FPH;
            fph <= 1'b1;
          end
        end
        default: begin
          st   <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sigmoid_neuron_trainer.sv
// Single Q8.8 sigmoid neuron with on-chip SGD; MAC, PWL sigmoid and weight update driven by arch_ctrl strobes.
// Build option NEURON_SAT_EN (see nn_pkg::fit) selects saturating arithmetic.
module sigmoid_neuron_trainer
  import nn_pkg::*;
#(
  parameter int N      = 6,
  parameter int BITS   = 16,
  parameter int EPOCHS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tr,
  input  logic                   vl,
  input  logic [N-1:0][BITS-1:0] x,
  input  logic [N-1:0][BITS-1:0] w_init,
  input  logic [BITS-1:0]        b_init,
  input  logic [BITS-1:0]        y_true,
  input  logic [BITS-1:0]        lr,
  output logic                   fph,
  output logic                   fpo,
  output logic                   bph,
  output logic                   bpo,
  output logic                   busy,
  output logic                   done,
  output logic [BITS-1:0]        y,
  output logic [BITS-1:0]        dz
);

  q8_8_t              w [N];
  q8_8_t              w_next [N];
  q8_8_t              b, b_next;
  q8_8_t              z, z_next;
  q8_8_t              g;
  q8_8_t              y_r, dz_r;
  logic signed [31:0] acc;

  arch_ctrl #(.EPOCHS(EPOCHS)) u_ctrl (
    .clk  (clk),
    .rst  (rst),
    .tr   (tr),
    .vl   (vl),
    .fph  (fph),
    .fpo  (fpo),
    .bpo  (bpo),
    .bph  (bph),
    .busy (busy),
    .done (done)
  );

  always_comb begin
    acc = 32'(b);
    for (int i = 0; i < N; i++) begin
      acc = acc + 32'(fit(mul(w[i], q8_8_t'(x[i]))));
    end
    z_next = fit(acc);
    g      = fit(mul(q8_8_t'(lr), dz_r));
    b_next = fit(32'(b) - 32'(g));
    for (int i = 0; i < N; i++) begin
      w_next[i] = fit(32'(w[i]) - 32'(fit(mul(g, q8_8_t'(x[i])))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_r  <= '0;
      dz_r <= '0;
      b    <= q8_8_t'(b_init);
      for (int i = 0; i < N; i++) w[i] <= q8_8_t'(w_init[i]);
    end else begin
      // busy low means the controller is idle and will accept tr this cycle
      if (tr && !busy) begin
        b <= q8_8_t'(b_init);
        for (int i = 0; i < N; i++) w[i] <= q8_8_t'(w_init[i]);
      end
      if (fph) z    <= z_next;
      if (fpo) y_r  <= sig(z);
      if (bpo) dz_r <= y_r - q8_8_t'(y_true);
      if (bph) begin
        b <= b_next;
        for (int i = 0; i < N; i++) w[i] <= w_next[i];
      end
    end
  end

  assign y  = y_r;
  assign dz = dz_r;

endmodule

// File: tb/tb_sigmoid_neuron_trainer.sv
// Directed bench for sigmoid_neuron_trainer: validation-pass vector table plus training/reset sequences.
module tb_sigmoid_neuron_trainer;

  localparam int N = 6, BITS = 16, EPOCHS = 1;
  typedef logic [N-1:0][BITS-1:0] vecw_t;

  logic clk = 1'b0;
  logic rst, tr, vl;
  vecw_t x, w_init;
  logic [BITS-1:0] b_init, y_true, lr, y, dz;
  logic fph, fpo, bph, bpo, busy, done;

  sigmoid_neuron_trainer #(.N(N), .BITS(BITS), .EPOCHS(EPOCHS)) dut (
    .clk(clk), .rst(rst), .tr(tr), .vl(vl), .x(x), .w_init(w_init),
    .b_init(b_init), .y_true(y_true), .lr(lr), .fph(fph), .fpo(fpo),
    .bph(bph), .bpo(bpo), .busy(busy), .done(done), .y(y), .dz(dz)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int bp_seen = 0;
  always @(posedge clk) if (bpo || bph) bp_seen <= bp_seen + 1;

  typedef struct {
    string           nm;
    vecw_t           x;
    vecw_t           w;
    logic [BITS-1:0] b;
    logic [BITS-1:0] ey;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vecw_t one(input logic [15:0] v);
    return vecw_t'({80'h0, v});
  endfunction

  task automatic add(input string nm, input vecw_t xv, input vecw_t wv,
                     input logic [15:0] bv, input logic [15:0] ey);
    vec_t e;
    e.nm = nm; e.x = xv; e.w = wv; e.b = bv; e.ey = ey;
    vt.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tr = 1'b0; vl = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic wait_done(input string nm, output int lat);
    bit ok;
    ok = 1'b0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        ok = 1'b1;
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_vl(input string nm, output int lat);
    vl = 1'b1;
    @(negedge clk);
    vl = 1'b0;
    wait_done(nm, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bp0;
    logic [4:0] seq [5];
    seq[0] = 5'b10000; seq[1] = 5'b01000; seq[2] = 5'b00100;
    seq[3] = 5'b00010; seq[4] = 5'b00001;

    rst = 1'b0; tr = 1'b0; vl = 1'b0;
    x = '0; w_init = '0; b_init = '0; y_true = '0; lr = 16'h0100;

    // Reset state
    do_reset();
    chk("rst_strobes", {27'd0, fph, fpo, bpo, bph, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_y", {16'd0, y}, 32'h0000);
    chk("rst_dz", {16'd0, dz}, 32'h0000);

    // Validation vectors; reset loads w_init/b_init as the weights under test
    add("sig_zero", '0, '0, 16'h0000, 16'h0080);
    add("mix_neg", {16'hFEEF, 16'h0201, 16'h0100, 16'h0100, 16'h0100, 16'h0100},
                   {16'h0400, 16'hFD00, 16'h0100, 16'h0100, 16'h0100, 16'h0100},
                   16'h0000, 16'h0000);
    add("u_1_0", one(16'h0100), one(16'h0100), 16'h0000, 16'h00C0);
    add("u_0_996", one(16'h0100), one(16'h00FF), 16'h0000, 16'h00BF);
    add("u_2_371", one(16'h0100), one(16'h025F), 16'h0000, 16'h00EB);
    add("u_2_375", one(16'h0100), one(16'h0260), 16'h0000, 16'h00EB);
    add("u_4_996", one(16'h0100), one(16'h04FF), 16'h0000, 16'h00FF);
    add("u_5_0", one(16'h0100), one(16'h0500), 16'h0000, 16'h0100);
    add("z_m1_0", '0, '0, 16'hFF00, 16'h0040);
    add("z_m0_5", '0, '0, 16'hFF80, 16'h0060);
    add("z_min", '0, '0, 16'h8000, 16'h0000);
`ifdef NEURON_SAT_EN
    add("ovf_mul", one(16'h7F00), one(16'h7F00), 16'h0000, 16'h0100);
`else
    add("ovf_mul", one(16'h7F00), one(16'h7F00), 16'h0000, 16'h00C0);
`endif

    foreach (vt[i]) begin
      x = vt[i].x; w_init = vt[i].w; b_init = vt[i].b; y_true = '0;
      do_reset();
      bp0 = bp_seen;
      run_vl(vt[i].nm, lat);
      chk({vt[i].nm, "_y"}, {16'd0, y}, {16'd0, vt[i].ey});
      chk({vt[i].nm, "_dz"}, {16'd0, dz}, 32'h0000);
      chk({vt[i].nm, "_nobp"}, bp_seen, bp0);
      if (i == 0) chk("vl_latency", lat, 32'd2);
    end

    // One training epoch from all-zero weights, then validation with updated bias
    x = '0; w_init = '0; b_init = '0; y_true = '0; lr = 16'h0100;
    do_reset();
    tr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tr = 1'b0;
      chk($sformatf("trn_strobe_c%0d", k + 1), {27'd0, fph, fpo, bpo, bph, done}, {27'd0, seq[k]});
    end
    @(negedge clk);
    chk("trn_idle_busy", {31'd0, busy}, 32'd0);
    chk("trn_y", {16'd0, y}, 32'h0080);
    chk("trn_dz", {16'd0, dz}, 32'h0080);
    run_vl("post_trn", lat);
    chk("post_trn_y", {16'd0, y}, 32'h0060);
    chk("post_trn_dz", {16'd0, dz}, 32'h0080);

    // tr and vl together: training wins, weights reloaded; tr while busy ignored
    tr = 1'b1; vl = 1'b1;
    @(negedge clk);
    tr = 1'b0; vl = 1'b0;
    @(negedge clk);
    tr = 1'b1;
    @(negedge clk);
    tr = 1'b0;
    chk("trvl_bpo", {31'd0, bpo}, 32'd1);
    wait_done("trvl", lat);
    chk("busy_tr_ignored", {31'd0, busy}, 32'd0);
    chk("trvl_y", {16'd0, y}, 32'h0080);

    // Reset during BPO aborts and reloads the (now changed) initial bias
    tr = 1'b1;
    @(negedge clk);
    tr = 1'b0;
    b_init = 16'h0100;
    repeat (2) @(negedge clk);
    chk("abort_in_bpo", {31'd0, bpo}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_strobes", {26'd0, fph, fpo, bpo, bph, done, busy}, 32'd0);
    chk("abort_y", {16'd0, y}, 32'h0000);
    chk("abort_dz", {16'd0, dz}, 32'h0000);
    run_vl("abort_vl", lat);
    chk("abort_reload_y", {16'd0, y}, 32'h00C0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
